sdram_init_refresh_sched: RTL and testbench
===========================================

Name: sdram_init_refresh_sched

Overview:
- Command-bus owner for the on-package 2M x 32 SDRAM (11-bit addr, 2-bit bank) on the Tang board.
- Runs the JEDEC power-up sequence and schedules periodic AUTO REFRESH.
- Grants the command bus to a single user controller (SoC SDRAM core) through a req/gnt handshake, muxing its commands onto registered pins.
- Sits between the SoC SDRAM core and the SDRAM PHY. DQ/DQM stay with the user and are not touched.

Parameters:
- INIT_WAIT_CYC, 4800: NOP cycles after reset before the first command (200 us at 24 MHz).
- TRP_CYC, 2: PRECHARGE to next command, in cycles.
- TRFC_CYC, 4: AUTO REFRESH to next command, in cycles.
- TMRD_CYC, 2: LOAD MODE to first user command, in cycles.
- REFI_CYC, 187: refresh interval in cycles (7.8 us at 24 MHz).
- URGENT_DEBT, 4: owed refreshes at which refresh_urgent asserts.
- MODE_REG, 11'h020: value driven on addr during LOAD MODE (CL2, BL1, sequential).

Ports:
- clk  in  1  system clock; also the SDRAM clock domain.
- resetN  in  1  asynchronous, active-low reset.
- usr_req  in  1  user requests the command bus.
- usr_gnt  out  1  bus granted; user commands are valid only while high.
- usr_cs_n, usr_ras_n, usr_cas_n, usr_we_n  in  1 each  user command.
- usr_addr  in  11  user address.
- usr_ba  in  2  user bank.
- refresh_pending  out  1  one or more refreshes owed.
- refresh_urgent  out  1  debt >= URGENT_DEBT.
- refresh_overflow  out  1  sticky: a refresh interval expired with debt already 8.
- init_done  out  1  init sequence complete.
- sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  registered SDRAM pins.
- sdram_addr  out  11  registered SDRAM address.
- sdram_ba  out  2  registered SDRAM bank.

Behaviour:
- Reset values:
  - sdram_cke=0; cs_n, ras_n, cas_n, we_n all 1; addr=0; ba=0.
  - init_done=0, usr_gnt=0, debt=0, overflow=0; state RST_WAIT.
- Any resetN assertion, including mid-init, mid-refresh or mid-grant, returns every output to its reset value immediately. The full init sequence then restarts.
- Command encoding {cs,ras,cas,we}: NOP=0111, PRECHARGE ALL=0010 with addr[10]=1, AUTO REFRESH=0001, LOAD MODE=0000 with addr=MODE_REG and ba=0.
- Any controller-owned cycle with no command drives NOP.
- Cycle numbering: cycle 0 is the first clk edge after resetN rises. sdram_cke=1 from cycle 0 onward.
- Init sequence, with W=INIT_WAIT_CYC:
  - NOP for cycles 0..W-1.
  - PRE at W.
  - REF at W+TRP_CYC.
  - REF at W+TRP_CYC+TRFC_CYC.
  - MRS at W+TRP_CYC+2*TRFC_CYC.
  - init_done=1 and state IDLE at W+TRP_CYC+2*TRFC_CYC+TMRD_CYC.
- Init FSM states: RST_WAIT, I_PRE, I_REF1, I_REF2, I_MRS, I_MRS_WAIT, then IDLE. Wait counts live in a shared down-counter.
- Refresh timer:
  - Starts counting when init_done rises.
  - Reloads REFI_CYC-1 on expiry and increments debt, saturating at 8.
  - Expiry with debt=8 sets refresh_overflow (sticky until reset).
  - Debt decrements on the cycle REF is driven. Expiry and decrement in the same cycle leave debt unchanged.
- Status flags: refresh_pending = (debt!=0); refresh_urgent = (debt>=URGENT_DEBT). Both come straight from the debt register.
- IDLE arbitration, evaluated each cycle; refresh has priority:
  - debt!=0: PRE at t+1, REF at t+1+TRP_CYC, back in IDLE at t+1+TRP_CYC+TRFC_CYC. States R_PRE, R_REF, R_WAIT.
  - else usr_req=1: usr_gnt=1 at t+1, state USER.
- USER state:
  - Pins take usr_* with one-cycle register latency; usr_gnt stays 1.
  - Refresh is never preempted; the user must watch pending/urgent.
  - When usr_req=0 at cycle t: usr_gnt=0 and pins NOP at t+1, state IDLE.
- Only one refresh per IDLE visit; IDLE re-arbitrates afterwards, so an owed refresh wins again.
- sdram_cke stays 1 after init; no power-down or self-refresh.

Decomposition:
- Shared package sdram_cmd_pkg holds:
  - SDRAM command 4-bit encodings (NOP/PRE/REF/MRS/ACT/RD/WR);
  - ADDR_W=11 and BA_W=2;
  - FSM state enum.
- One natural sub-module: sdram_refresh_timer, holding the REFI counter, saturating debt and the overflow flag.

Test Plan:
- Init timing with W=10, TRP=2, TRFC=4, TMRD=2 -> PRE@10, REF@12, REF@16, MRS@20 with addr=0x020, init_done@22; NOP on every other cycle; usr_req held high gets usr_gnt only at 23.
- Grant and pass-through: usr_req=1 in IDLE with debt=0 -> usr_gnt next cycle; usr ACT bank 2 row 0x155 appears on pins one cycle later; usr_req=0 -> gnt=0 and NOP next cycle.
- Refresh deferral with REFI=50: user holds the bus across two expiries -> refresh_pending=1, debt=2, no REF on pins. Release -> PRE, REF, PRE, REF back-to-back (intervals 2 and 4 cycles), debt 0, then a new grant is possible.
- Urgent and overflow: hold the bus across 4 expiries -> refresh_urgent=1. Across 9 expiries -> debt stays 8 and refresh_overflow=1, remaining 1 after the debt is drained.
- Simultaneous events: timer expiry on the same cycle as a REF issue -> debt unchanged. usr_req and debt>0 both present in IDLE -> refresh runs first.
- Reset mid-refresh: assert resetN low between PRE and REF -> pins reset immediately (cke=0, cs_n=1), init_done=0; on release, PRE appears again at cycle W.

Source files
------------

// File: rtl/sdram_cmd_pkg.sv
// Shared SDRAM command encodings, bus widths and scheduler state type.
package sdram_cmd_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned BA_W   = 2;
  localparam int unsigned CMD_W  = 4;

  // {cs_n, ras_n, cas_n, we_n}
  typedef logic [CMD_W-1:0] cmd_t;

  localparam cmd_t CMD_DESL = 4'b1111;
  localparam cmd_t CMD_NOP  = 4'b0111;
  localparam cmd_t CMD_PRE  = 4'b0010;
  localparam cmd_t CMD_REF  = 4'b0001;
  localparam cmd_t CMD_MRS  = 4'b0000;
  localparam cmd_t CMD_ACT  = 4'b0011;
  localparam cmd_t CMD_RD   = 4'b0101;
  localparam cmd_t CMD_WR   = 4'b0100;

  typedef struct packed {
    cmd_t              cmd;
    logic [ADDR_W-1:0] addr;
    logic [BA_W-1:0]   ba;
  } sdram_bus_t;

  typedef enum logic [3:0] {
    RST_WAIT,
    I_PRE,
    I_REF1,
    I_REF2,
    I_MRS,
    I_MRS_WAIT,
    IDLE,
    R_PRE,
    R_REF,
    R_WAIT,
    USER
  } sched_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval timer with saturating refresh debt and sticky overflow.
module sdram_refresh_timer
  import sdram_cmd_pkg::*;
#(
  parameter int unsigned REFI_CYC    = 187,
  parameter int unsigned URGENT_DEBT = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic i_en,
  input  logic i_ref_issue,
  output logic o_pending,
  output logic o_urgent,
  output logic o_overflow
);

  localparam int unsigned CNT_W    = $clog2(REFI_CYC + 1);
  localparam int unsigned DEBT_W   = 4;
  localparam int unsigned DEBT_MAX = 8;

  logic [CNT_W-1:0]  r_cnt;
  logic [DEBT_W-1:0] r_debt;
  logic              r_pending;
  logic              r_urgent;
  logic              r_overflow;
  logic              w_expire;
  logic [DEBT_W-1:0] w_debt_nxt;

  assign w_expire = i_en && (r_cnt == '0);

  // An expiry and a REF in the same cycle cancel out.
  always_comb begin
    w_debt_nxt = r_debt;
    if (w_expire && !i_ref_issue && (r_debt != DEBT_W'(DEBT_MAX))) begin
      w_debt_nxt = r_debt + DEBT_W'(1);
    end else if (i_ref_issue && !w_expire) begin
      w_debt_nxt = r_debt - DEBT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt      <= CNT_W'(REFI_CYC - 1);
      r_debt     <= '0;
      r_pending  <= 1'b0;
      r_urgent   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (i_en) begin
        r_cnt <= w_expire ? CNT_W'(REFI_CYC - 1) : (r_cnt - CNT_W'(1));
      end
      r_debt    <= w_debt_nxt;
      r_pending <= (w_debt_nxt != '0);
      r_urgent  <= (w_debt_nxt >= DEBT_W'(URGENT_DEBT));
      if (w_expire && (r_debt == DEBT_W'(DEBT_MAX))) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_pending  = r_pending;
  assign o_urgent   = r_urgent;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/sdram_init_refresh_sched.sv
// SDRAM command-bus owner: power-up sequence, periodic AUTO REFRESH and
// req/gnt hand-over of the registered command pins to the user controller.
module sdram_init_refresh_sched
  import sdram_cmd_pkg::*;
#(
  parameter int unsigned       INIT_WAIT_CYC = 4800,
  parameter int unsigned       TRP_CYC       = 2,
  parameter int unsigned       TRFC_CYC      = 4,
  parameter int unsigned       TMRD_CYC      = 2,
  parameter int unsigned       REFI_CYC      = 187,
  parameter int unsigned       URGENT_DEBT   = 4,
  parameter logic [ADDR_W-1:0] MODE_REG      = 11'h020
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              usr_req,
  output logic              usr_gnt,
  input  logic              usr_cs_n,
  input  logic              usr_ras_n,
  input  logic              usr_cas_n,
  input  logic              usr_we_n,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [BA_W-1:0]   usr_ba,
  output logic              refresh_pending,
  output logic              refresh_urgent,
  output logic              refresh_overflow,
  output logic              init_done,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_ba
);

  localparam int unsigned WAIT_MAX =
    max_u(max_u(INIT_WAIT_CYC, TRP_CYC), max_u(TRFC_CYC, TMRD_CYC));
  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  localparam sdram_bus_t BUS_RST = '{cmd: CMD_DESL, addr: '0, ba: '0};
  localparam sdram_bus_t BUS_NOP = '{cmd: CMD_NOP,  addr: '0, ba: '0};
  localparam sdram_bus_t BUS_PRE = '{cmd: CMD_PRE,  addr: ADDR_W'(1 << 10), ba: '0};
  localparam sdram_bus_t BUS_REF = '{cmd: CMD_REF,  addr: '0, ba: '0};
  localparam sdram_bus_t BUS_MRS = '{cmd: CMD_MRS,  addr: MODE_REG, ba: '0};

  sched_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cke;
  logic             r_gnt;
  logic             r_init_done;
  sdram_bus_t       r_bus;
  logic             w_ref_issue;
  logic             w_pending;

  // REF is driven on the edge that leaves R_PRE; the timer debits on that edge.
  assign w_ref_issue = (r_state == R_PRE) && (r_cnt == '0);

  sdram_refresh_timer #(
    .REFI_CYC    (REFI_CYC),
    .URGENT_DEBT (URGENT_DEBT)
  ) u_refresh_timer (
    .clk         (clk),
    .resetN      (resetN),
    .i_en        (r_init_done),
    .i_ref_issue (w_ref_issue),
    .o_pending   (w_pending),
    .o_urgent    (refresh_urgent),
    .o_overflow  (refresh_overflow)
  );

  // Each command loads r_cnt with (gap - 1); the next step fires when it hits zero.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= RST_WAIT;
      r_cnt       <= CNT_W'(INIT_WAIT_CYC);
      r_cke       <= 1'b0;
      r_gnt       <= 1'b0;
      r_init_done <= 1'b0;
      r_bus       <= BUS_RST;
    end else begin
      r_cke <= 1'b1;
      r_bus <= BUS_NOP;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      case (r_state)
        RST_WAIT: if (r_cnt == '0) begin
          r_bus   <= BUS_PRE;
          r_cnt   <= CNT_W'(TRP_CYC - 1);
          r_state <= I_PRE;
        end
        I_PRE: if (r_cnt == '0) begin
          r_bus   <= BUS_REF;
          r_cnt   <= CNT_W'(TRFC_CYC - 1);
          r_state <= I_REF1;
        end
        I_REF1: if (r_cnt == '0) begin
          r_bus   <= BUS_REF;
          r_cnt   <= CNT_W'(TRFC_CYC - 1);
          r_state <= I_REF2;
        end
        I_REF2: if (r_cnt == '0) begin
          r_bus   <= BUS_MRS;
          r_cnt   <= CNT_W'(TMRD_CYC - 1);
          r_state <= I_MRS;
        end
        I_MRS, I_MRS_WAIT: begin
          if (r_cnt == '0) begin
            r_init_done <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_state <= I_MRS_WAIT;
          end
        end
        // Owed refresh always beats a user request.
        IDLE: begin
          if (w_pending) begin
            r_bus   <= BUS_PRE;
            r_cnt   <= CNT_W'(TRP_CYC - 1);
            r_state <= R_PRE;
          end else if (usr_req) begin
            r_gnt   <= 1'b1;
            r_state <= USER;
          end
        end
        R_PRE: if (r_cnt == '0) begin
          r_bus   <= BUS_REF;
          r_cnt   <= CNT_W'(TRFC_CYC - 1);
          r_state <= R_REF;
        end
        R_REF, R_WAIT: begin
          r_state <= (r_cnt == '0) ? IDLE : R_WAIT;
        end
        USER: begin
          if (usr_req) begin
            r_bus <= '{cmd:  {usr_cs_n, usr_ras_n, usr_cas_n, usr_we_n},
                       addr: usr_addr,
                       ba:   usr_ba};
          end else begin
            r_gnt   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= RST_WAIT;
      endcase
    end
  end

  assign usr_gnt         = r_gnt;
  assign init_done       = r_init_done;
  assign refresh_pending = w_pending;
  assign sdram_cke       = r_cke;
  assign sdram_cs_n      = r_bus.cmd[3];
  assign sdram_ras_n     = r_bus.cmd[2];
  assign sdram_cas_n     = r_bus.cmd[1];
  assign sdram_we_n      = r_bus.cmd[0];
  assign sdram_addr      = r_bus.addr;
  assign sdram_ba        = r_bus.ba;

endmodule

// File: tb/tb_sdram_init_refresh_sched.sv
// Bench for sdram_init_refresh_sched: vector table, directed corner sequences
// and randomized traffic against a timestamp-based reference model.
module tb_sdram_init_refresh_sched;
  import sdram_cmd_pkg::*;

  localparam int W    = 10;
  localparam int TRP  = 2;
  localparam int TRFC = 4;
  localparam int TMRD = 2;
  localparam int REFI = 50;
  localparam int URG  = 4;
  localparam int D    = W + TRP + 2 * TRFC + TMRD;
  localparam logic [10:0] MODE = 11'h020;
  localparam logic [10:0] A10  = 11'h400;
  localparam int OWN_FREE = 0;
  localparam int OWN_USER = 1;
  localparam int OWN_REF  = 2;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        usr_req = 1'b0;
  cmd_t        u_cmd = CMD_NOP;
  logic [10:0] u_addr = '0;
  logic [1:0]  u_ba = '0;
  logic        usr_gnt, refresh_pending, refresh_urgent, refresh_overflow, init_done;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [10:0] sdram_addr;
  logic [1:0]  sdram_ba;

  sdram_init_refresh_sched #(
    .INIT_WAIT_CYC(W), .TRP_CYC(TRP), .TRFC_CYC(TRFC), .TMRD_CYC(TMRD),
    .REFI_CYC(REFI), .URGENT_DEBT(URG), .MODE_REG(MODE)
  ) dut (
    .clk(clk), .resetN(resetN), .usr_req(usr_req), .usr_gnt(usr_gnt),
    .usr_cs_n(u_cmd[3]), .usr_ras_n(u_cmd[2]), .usr_cas_n(u_cmd[1]), .usr_we_n(u_cmd[0]),
    .usr_addr(u_addr), .usr_ba(u_ba),
    .refresh_pending(refresh_pending), .refresh_urgent(refresh_urgent),
    .refresh_overflow(refresh_overflow), .init_done(init_done),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_addr(sdram_addr), .sdram_ba(sdram_ba)
  );

  always #5 clk = ~clk;

  cmd_t        dut_cmd;
  logic [22:0] dut_v;
  assign dut_cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign dut_v   = {sdram_cke, dut_cmd, sdram_addr, sdram_ba, usr_gnt, init_done,
                    refresh_pending, refresh_urgent, refresh_overflow};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycle k counts edges since reset release.
  int          k;
  int          m_debt;
  int          m_own;
  int          m_rp;
  logic        m_ovf;
  logic        m_gnt;
  cmd_t        m_cmd;
  logic [10:0] m_addr;
  logic [1:0]  m_ba;

  function automatic logic [22:0] model_v();
    return {1'b1, m_cmd, m_addr, m_ba, m_gnt, 1'(k >= D), 1'(m_debt != 0),
            1'(m_debt >= URG), m_ovf};
  endfunction

  task automatic model_edge();
    logic dec, expire;
    dec = 1'b0;
    m_cmd = CMD_NOP; m_addr = '0; m_ba = '0;
    if (k < D) begin
      if (k == W) begin m_cmd = CMD_PRE; m_addr = A10; end
      else if (k == W + TRP || k == W + TRP + TRFC) m_cmd = CMD_REF;
      else if (k == W + TRP + 2 * TRFC) begin m_cmd = CMD_MRS; m_addr = MODE; end
    end else if (k > D) begin
      case (m_own)
        OWN_FREE: begin
          if (m_debt != 0) begin
            m_cmd = CMD_PRE; m_addr = A10; m_own = OWN_REF; m_rp = k;
          end else if (usr_req) begin
            m_gnt = 1'b1; m_own = OWN_USER;
          end
        end
        OWN_USER: begin
          if (usr_req) begin m_cmd = u_cmd; m_addr = u_addr; m_ba = u_ba; end
          else begin m_gnt = 1'b0; m_own = OWN_FREE; end
        end
        default: begin
          if (k == m_rp + TRP) begin m_cmd = CMD_REF; dec = 1'b1; end
          else if (k == m_rp + TRP + TRFC) m_own = OWN_FREE;
        end
      endcase
    end
    expire = (k > D) && (((k - D) % REFI) == 0);
    if (expire && m_debt == 8) m_ovf = 1'b1;
    if (expire && !dec && m_debt < 8) m_debt = m_debt + 1;
    else if (dec && !expire) m_debt = m_debt - 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    model_edge();
    #1;
    chk("model", 32'(dut_v), 32'(model_v()));
  endtask

  task automatic run_until(input int c);
    while (k < c) step();
  endtask

  task automatic drive(input logic req, input cmd_t c, input logic [10:0] a, input logic [1:0] b);
    usr_req = req; u_cmd = c; u_addr = a; u_ba = b;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    #1;
    chk("reset_outputs", 32'(dut_v), 32'({1'b0, CMD_DESL, 11'd0, 2'd0, 5'd0}));
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    k = -1; m_debt = 0; m_own = OWN_FREE; m_rp = 0; m_ovf = 1'b0; m_gnt = 1'b0;
  endtask

  typedef struct {
    logic        req;
    cmd_t        ucmd;
    logic [10:0] uaddr;
    logic [1:0]  uba;
    cmd_t        ecmd;
    logic [10:0] eaddr;
    logic [1:0]  eba;
    logic        egnt;
    logic        edone;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl[NV];
  int   ev_k[$];
  cmd_t ev_c[$];
  int   ref_seen;

  initial begin
    // Row i: inputs present before edge i, outputs expected after edge i.
    for (int i = 0; i < NV; i++) begin
      tbl[i] = '{1'b1, CMD_NOP, 11'd0, 2'd0, CMD_NOP, 11'd0, 2'd0, 1'b0, 1'(i >= 22)};
    end
    tbl[10].ecmd = CMD_PRE; tbl[10].eaddr = 11'h400;
    tbl[12].ecmd = CMD_REF;
    tbl[16].ecmd = CMD_REF;
    tbl[20].ecmd = CMD_MRS; tbl[20].eaddr = 11'h020;
    tbl[23].egnt = 1'b1;
    tbl[24].egnt = 1'b1; tbl[24].ucmd = CMD_ACT; tbl[24].uaddr = 11'h155; tbl[24].uba = 2'd2;
    tbl[24].ecmd = CMD_ACT; tbl[24].eaddr = 11'h155; tbl[24].eba = 2'd2;
    tbl[25].egnt = 1'b1;
    tbl[26].req = 1'b0;
    tbl[27].req = 1'b0;

    #3;
    // Init timing, grant and pass-through.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].req, tbl[i].ucmd, tbl[i].uaddr, tbl[i].uba);
      step();
      chk("table", 32'({sdram_cke, dut_cmd, sdram_addr, sdram_ba, usr_gnt, init_done}),
          32'({1'b1, tbl[i].ecmd, tbl[i].eaddr, tbl[i].eba, tbl[i].egnt, tbl[i].edone}));
    end

    // Deferral across two expiries, then back-to-back drain.
    do_reset();
    drive(1'b1, CMD_NOP, '0, '0);
    ref_seen = 0;
    while (k < D + 2 * REFI + 3) begin
      step();
      if (k > D && dut_cmd == CMD_REF) ref_seen++;
    end
    chk("defer_no_ref", 32'(ref_seen), 0);
    chk("defer_flags", 32'({usr_gnt, refresh_pending, refresh_urgent}), 32'(3'b110));
    drive(1'b0, CMD_NOP, '0, '0);
    step();
    chk("defer_release_gnt", 32'(usr_gnt), 0);
    while (k < 140) begin
      step();
      if (dut_cmd != CMD_NOP) begin ev_k.push_back(k); ev_c.push_back(dut_cmd); end
    end
    chk("defer_nevents", 32'(ev_k.size()), 4);
    if (ev_k.size() == 4) begin
      chk("defer_ev0", 32'({ev_k[0], ev_c[0]}), 32'({127, CMD_PRE}));
      chk("defer_ev1", 32'({ev_k[1], ev_c[1]}), 32'({129, CMD_REF}));
      chk("defer_ev2", 32'({ev_k[2], ev_c[2]}), 32'({134, CMD_PRE}));
      chk("defer_ev3", 32'({ev_k[3], ev_c[3]}), 32'({136, CMD_REF}));
    end
    chk("defer_drained", 32'(refresh_pending), 0);
    drive(1'b1, CMD_NOP, '0, '0);
    step();
    chk("defer_regrant", 32'(usr_gnt), 1);

    // Urgent after four expiries, overflow on the ninth.
    do_reset();
    drive(1'b1, CMD_NOP, '0, '0);
    run_until(D + 3 * REFI);
    chk("urgent_before", 32'(refresh_urgent), 0);
    run_until(D + 4 * REFI);
    chk("urgent_at4", 32'(refresh_urgent), 1);
    run_until(D + 9 * REFI - 1);
    chk("ovf_before", 32'(refresh_overflow), 0);
    step();
    chk("ovf_at9", 32'({refresh_overflow, refresh_pending, refresh_urgent}), 32'(3'b111));
    drive(1'b0, CMD_NOP, '0, '0);
    run_until(600);
    chk("ovf_sticky", 32'({refresh_overflow, refresh_pending, refresh_urgent}), 32'(3'b100));

    // Expiry coinciding with REF, then refresh beating a pending request.
    do_reset();
    drive(1'b1, CMD_NOP, '0, '0);
    run_until(D + 2 * REFI - 4);
    drive(1'b0, CMD_NOP, '0, '0);
    run_until(D + 2 * REFI - 2);
    chk("simul_pre", 32'(dut_cmd), 32'(CMD_PRE));
    run_until(D + 2 * REFI);
    chk("simul_ref", 32'({dut_cmd, refresh_pending}), 32'({CMD_REF, 1'b1}));
    drive(1'b1, CMD_NOP, '0, '0);
    run_until(127);
    chk("prio_pre", 32'({dut_cmd, usr_gnt}), 32'({CMD_PRE, 1'b0}));
    run_until(133);
    chk("prio_nogrant", 32'(usr_gnt), 0);
    step();
    chk("prio_grant", 32'({usr_gnt, refresh_pending}), 32'(2'b10));

    // Reset between PRE and REF restarts init.
    do_reset();
    drive(1'b0, CMD_NOP, '0, '0);
    run_until(D + REFI + 1);
    chk("midref_pre", 32'(dut_cmd), 32'(CMD_PRE));
    step();
    #2;
    do_reset();
    run_until(W - 1);
    chk("reinit_nop", 32'({sdram_cke, dut_cmd, init_done}), 32'({1'b1, CMD_NOP, 1'b0}));
    step();
    chk("reinit_pre", 32'({dut_cmd, sdram_addr}), 32'({CMD_PRE, 11'h400}));

    // Randomized traffic against the model.
    do_reset();
    drive(1'b0, CMD_NOP, '0, '0);
    for (int n = 0; n < 4000; n++) begin
      if (usr_req ? ($urandom_range(149) == 0) : ($urandom_range(19) == 0)) usr_req = ~usr_req;
      case ($urandom_range(3))
        0: u_cmd = CMD_NOP;
        1: u_cmd = CMD_ACT;
        2: u_cmd = CMD_RD;
        default: u_cmd = CMD_WR;
      endcase
      u_addr = 11'($urandom);
      u_ba   = 2'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
